// File: rtl/inst_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_unit_pkg
//  Brief    : Shared types for the fetch unit, mem_ctrler and issuer.
//  Revision : 1.0 - initial release
// ============================================================================
package inst_fetch_unit_pkg;

    typedef logic [31:0]  addr_t;
    typedef logic [31:0]  data_t;
    typedef logic [31:0]  inst_t;
    typedef logic [127:0] cache_line_t;

    localparam addr_t c_INST_BYTES = 32'd4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MISS = 1'b1
    } fetch_state_t;

    function automatic addr_t line_base(input addr_t a, input int unsigned line_bytes);
        return a & ~(addr_t'(line_bytes) - addr_t'(1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_unit_if
//  Brief    : Refill channel to mem_ctrler and issue channel to issuer.
//  Revision : 1.0 - initial release
// ============================================================================
interface inst_fetch_unit_if;
    import inst_fetch_unit_pkg::*;

    logic        valid_to_mem_ctrler;
    addr_t       addr_to_mem_ctrler;
    logic        ready_from_mem_ctrler;
    cache_line_t cache_line_from_mem_ctrler;
    logic        ready_to_issuer;
    inst_t       inst_to_issuer;

    modport master (
        output valid_to_mem_ctrler,
        output addr_to_mem_ctrler,
        input  ready_from_mem_ctrler,
        input  cache_line_from_mem_ctrler,
        output ready_to_issuer,
        output inst_to_issuer
    );

    modport slave (
        input  valid_to_mem_ctrler,
        input  addr_to_mem_ctrler,
        output ready_from_mem_ctrler,
        output cache_line_from_mem_ctrler,
        input  ready_to_issuer,
        input  inst_to_issuer
    );

endinterface
`default_nettype wire

// File: rtl/inst_fetch_unit_icache.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_unit_icache
//  Brief    : Direct-mapped read-only I-cache: combinational lookup, refill port.
//  Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_unit_icache
    import inst_fetch_unit_pkg::*;
#(
    parameter int LINE_BYTES   = 16,
    parameter int ICACHE_LINES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  addr_t       i_rd_pc,
    output logic        o_rd_hit,
    output inst_t       o_rd_word,
    input  logic        i_wr_en,
    input  addr_t       i_wr_addr,
    input  cache_line_t i_wr_line
);

    localparam int c_OFF_W  = $clog2(LINE_BYTES);
    localparam int c_IDX_W  = $clog2(ICACHE_LINES);
    localparam int c_TAG_W  = 32 - c_OFF_W - c_IDX_W;
    localparam int c_WORDS  = LINE_BYTES / 4;
    localparam int c_WORD_W = c_OFF_W - 2;

    logic [c_TAG_W-1:0]      r_tag   [ICACHE_LINES];
    cache_line_t             r_data  [ICACHE_LINES];
    logic [ICACHE_LINES-1:0] r_valid;

    logic [c_IDX_W-1:0] w_rd_idx;
    logic [c_TAG_W-1:0] w_rd_tag;
    logic [c_IDX_W-1:0] w_wr_idx;
    logic [c_TAG_W-1:0] w_wr_tag;
    cache_line_t        w_rd_line;
    inst_t              w_words [c_WORDS];
    logic               w_unused_bits;

    assign w_rd_idx  = i_rd_pc[c_OFF_W +: c_IDX_W];
    assign w_rd_tag  = i_rd_pc[31 -: c_TAG_W];
    assign w_wr_idx  = i_wr_addr[c_OFF_W +: c_IDX_W];
    assign w_wr_tag  = i_wr_addr[31 -: c_TAG_W];
    assign w_rd_line = r_data[w_rd_idx];

    // Byte-offset bits below the word never select anything.
    assign w_unused_bits = ^{i_rd_pc[1:0], i_wr_addr[c_OFF_W-1:0]};

    generate
        for (genvar g = 0; g < c_WORDS; g++) begin : g_word
            assign w_words[g] = w_rd_line[g*32 +: 32];
        end
    endgenerate

    assign o_rd_hit  = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
    assign o_rd_word = w_words[i_rd_pc[2 +: c_WORD_W]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[w_wr_idx] <= 1'b1;
        end
    end

    // Tag and data need no reset: they are only trusted behind a valid bit.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[w_wr_idx]  <= w_wr_tag;
            r_data[w_wr_idx] <= i_wr_line;
        end
    end

endmodule
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_unit
//  Brief    : Sequential fetcher: PC, IDLE/MISS refill FSM and registered outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter addr_t RESET_PC     = 32'h0,
    parameter int    LINE_BYTES   = 16,
    parameter int    ICACHE_LINES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                stall,
    inst_fetch_unit_if.master   bus
);

    fetch_state_t r_state;
    addr_t        r_pc;
    logic         r_req_valid;
    addr_t        r_req_addr;
    logic         r_issue;
    inst_t        r_inst;

    logic  w_hit;
    inst_t w_word;
    logic  w_refill;

    // Refill only lands when the unit is live; a pulse outside MISS is dropped.
    assign w_refill = rst && rdy && (r_state == ST_MISS) && bus.ready_from_mem_ctrler;

    inst_fetch_unit_icache #(
        .LINE_BYTES   (LINE_BYTES),
        .ICACHE_LINES (ICACHE_LINES)
    ) u_icache (
        .clk       (clk),
        .rst       (rst),
        .i_rd_pc   (r_pc),
        .o_rd_hit  (w_hit),
        .o_rd_word (w_word),
        .i_wr_en   (w_refill),
        .i_wr_addr (r_req_addr),
        .i_wr_line (bus.cache_line_from_mem_ctrler)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_pc        <= RESET_PC;
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
            r_issue     <= 1'b0;
            r_inst      <= '0;
        end else if (!rdy) begin
            r_issue <= 1'b0;
        end else begin
            r_issue <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_hit) begin
                        if (!stall) begin
                            r_issue <= 1'b1;
                            r_inst  <= w_word;
                            r_pc    <= r_pc + c_INST_BYTES;
                        end
                    end else begin
                        r_state     <= ST_MISS;
                        r_req_valid <= 1'b1;
                        r_req_addr  <= line_base(r_pc, LINE_BYTES);
                    end
                end
                ST_MISS: begin
                    // The PC is frozen here, so the next lookup re-tries it and hits.
                    if (bus.ready_from_mem_ctrler) begin
                        r_state     <= ST_IDLE;
                        r_req_valid <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.valid_to_mem_ctrler = r_req_valid;
    assign bus.addr_to_mem_ctrler  = r_req_addr;
    assign bus.ready_to_issuer     = r_issue;
    assign bus.inst_to_issuer      = r_inst;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_fetch_unit
//  Brief    : Vector table, directed corner sequences and random traffic for the fetcher.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_unit;
    import inst_fetch_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic stall;

    inst_fetch_unit_if bus ();

    inst_fetch_unit #(
        .RESET_PC     (32'h0),
        .LINE_BYTES   (16),
        .ICACHE_LINES (16)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rdy   (rdy),
        .stall (stall),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Memory image: line 0 holds the known program, everything else a bijective hash.
    function automatic inst_t mem_word(input addr_t a);
        case (a)
            32'h0:   return 32'h00a00193;
            32'h4:   return 32'h00000113;
            32'h8:   return 32'h00100093;
            32'hC:   return 32'h00000013;
            default: return a * 32'h9E3779B9 + 32'h12345677;
        endcase
    endfunction

    function automatic cache_line_t make_line(input addr_t base);
        cache_line_t l;
        for (int i = 0; i < 4; i++) l[i*32 +: 32] = mem_word(base + addr_t'(4 * i));
        return l;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: resident line base per set, the fetch address stream, one outstanding request.
    addr_t m_resident [int];
    addr_t m_pc   = 32'h0;
    bit    m_wait = 1'b0;
    addr_t m_req  = 32'h0;
    bit    e_valid = 1'b0;
    addr_t e_addr  = 32'h0;
    bit    e_rti   = 1'b0;
    inst_t e_inst  = 32'h0;

    function automatic int set_of(input addr_t a);
        return int'((a / 16) % 16);
    endfunction

    function automatic bit m_cached(input addr_t a);
        return m_resident.exists(set_of(a)) && (m_resident[set_of(a)] == (a / 16) * 16);
    endfunction

    task automatic cycle(input logic r, input logic rd, input logic st, input logic mr);
        rst   = r;
        rdy   = rd;
        stall = st;
        bus.ready_from_mem_ctrler      = mr;
        bus.cache_line_from_mem_ctrler = make_line(bus.addr_to_mem_ctrler);
        e_rti = 1'b0;
        if (!r) begin
            m_resident.delete();
            m_pc    = 32'h0;
            m_wait  = 1'b0;
            e_valid = 1'b0;
            e_addr  = 32'h0;
            e_inst  = 32'h0;
        end else if (rd) begin
            if (m_wait) begin
                if (mr) begin
                    m_resident[set_of(m_req)] = m_req;
                    m_wait  = 1'b0;
                    e_valid = 1'b0;
                end
            end else if (m_cached(m_pc)) begin
                if (!st) begin
                    e_rti  = 1'b1;
                    e_inst = mem_word(m_pc);
                    m_pc   = m_pc + 32'd4;
                end
            end else begin
                m_wait  = 1'b1;
                m_req   = (m_pc / 16) * 16;
                e_valid = 1'b1;
                e_addr  = m_req;
            end
        end
        @(negedge clk);
        chk("valid_to_mem", 32'(bus.valid_to_mem_ctrler), 32'(e_valid));
        chk("ready_to_issuer", 32'(bus.ready_to_issuer), 32'(e_rti));
        if (e_valid || !r) chk("addr_to_mem", bus.addr_to_mem_ctrler, e_addr);
        if (e_rti || !r)   chk("inst_to_issuer", bus.inst_to_issuer, e_inst);
    endtask

    typedef struct {
        logic  rst;
        logic  rdy;
        logic  stall;
        logic  mrdy;
        logic  e_valid;
        addr_t e_addr;
        logic  e_rti;
        inst_t e_inst;
    } vec_t;

    vec_t tbl [19];

    initial begin
        bit found;

        rst = 1'b0; rdy = 1'b1; stall = 1'b0;
        bus.ready_from_mem_ctrler      = 1'b0;
        bus.cache_line_from_mem_ctrler = '0;
        @(negedge clk);

        // Cycle-exact vectors: reset, first refill, line crossing, stall, rdy drop, stray ready.
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 32'h0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 32'h0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h00a00193};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h00000113};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h00100093};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h00000013};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, mem_word(32'h10)};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, mem_word(32'h14)};
        tbl[16] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  1'b1, mem_word(32'h18)};
        tbl[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, mem_word(32'h1C)};
        tbl[18] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 32'h0};

        for (int i = 0; i < 19; i++) begin
            rst   = tbl[i].rst;
            rdy   = tbl[i].rdy;
            stall = tbl[i].stall;
            bus.ready_from_mem_ctrler      = tbl[i].mrdy;
            bus.cache_line_from_mem_ctrler = make_line(bus.addr_to_mem_ctrler);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), 32'(bus.valid_to_mem_ctrler), 32'(tbl[i].e_valid));
            chk($sformatf("vec%0d_rti", i), 32'(bus.ready_to_issuer), 32'(tbl[i].e_rti));
            if (tbl[i].e_valid || !tbl[i].rst)
                chk($sformatf("vec%0d_addr", i), bus.addr_to_mem_ctrler, tbl[i].e_addr);
            if (tbl[i].e_rti || !tbl[i].rst)
                chk($sformatf("vec%0d_inst", i), bus.inst_to_issuer, tbl[i].e_inst);
        end

        // Stream with a stall every 21 cycles and a 3-cycle rdy drop; runs past 0x100 to evict set 0.
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 400; c++) begin
            cycle(1'b1, !(c >= 200 && c < 203), (c % 21) == 20,
                  bus.valid_to_mem_ctrler && ($urandom_range(0, 1) == 1));
        end
        chk("stream_reached_past_0x100", 32'(m_pc > 32'h100), 32'd1);

        // Random traffic: rdy drops, stalls, variable latency, stray ready pulses, rare resets.
        for (int c = 0; c < 1500; c++) begin
            logic mr;
            mr = bus.valid_to_mem_ctrler ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 99) < 5);
            cycle($urandom_range(0, 199) != 0, $urandom_range(0, 9) != 0,
                  $urandom_range(0, 99) < 15, mr);
        end

        // Reset while a refill of 0x20 is outstanding, then a late ready pulse.
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (bus.valid_to_mem_ctrler && bus.addr_to_mem_ctrler == 32'h20) found = 1'b1;
            else cycle(1'b1, 1'b1, 1'b0, bus.valid_to_mem_ctrler);
        end
        n_checks++;
        if (!found) begin
            n_errors++;
            $display("FAIL reach_miss_0x20: got no request, expected addr 00000020");
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        chk("late_pulse_fresh_req_valid", 32'(bus.valid_to_mem_ctrler), 32'd1);
        chk("late_pulse_fresh_req_addr", bus.addr_to_mem_ctrler, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("after_reset_first_inst", bus.inst_to_issuer, 32'h00a00193);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, bus.valid_to_mem_ctrler);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
